// File: rtl/ccff_chain_loader.sv
// Configuration chain loader: serialises bitstream words MSB-first onto
// ccff_head and CRC-checks the chain through a non-destructive recirculating
// readback.
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 88*64,
  parameter int unsigned WORD_W    = 32
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              load_start,
  input  logic              rb_start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              crc_ok,
  output logic [15:0]       load_crc
);

  localparam int unsigned CW = $clog2(CHAIN_LEN + 1);
  localparam int unsigned RW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] LEN_C  = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] LAST_C = CW'(CHAIN_LEN - 1);
  localparam logic [15:0]   CRC_INIT = 16'hFFFF;
  localparam logic [15:0]   CRC_POLY = 16'h1021;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RB
  } state_t;

  state_t            state;
  state_t            state_nx;

  logic [WORD_W-1:0] sreg;      // word being shifted out, MSB at the top
  logic [RW-1:0]     reg_cnt;   // bits still to shift from sreg
  logic [CW-1:0]     acc;       // bits accepted from cfg_data so far
  logic [CW-1:0]     cnt;       // shift_en cycles in the current operation
  logic [15:0]       crc;
  logic [15:0]       crc_nx;
  logic              loaded;
  logic              crc_ok_q;
  logic              done_q;

  logic              shift_raw;
  logic              ready_raw;
  logic              head_raw;
  logic              last_shift;
  logic [CW-1:0]     rem;
  logic [RW-1:0]     take;
  logic              crc_fb;

  // State register
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode and chain-side strobes
  always_comb begin
    state_nx   = state;
    shift_raw  = 1'b0;
    ready_raw  = 1'b0;
    head_raw   = 1'b0;
    last_shift = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (load_start) begin
          state_nx = S_LOAD;
        end else if (rb_start) begin
          state_nx = S_RB;
        end
      end
      S_LOAD: begin
        shift_raw  = (reg_cnt != '0);
        head_raw   = sreg[WORD_W-1];
        // Ready while the last buffered bit drains so words stream with no gap.
        ready_raw  = ((reg_cnt == '0) || ((reg_cnt == RW'(1)) && shift_raw)) && (acc != LEN_C);
        last_shift = shift_raw && (cnt == LAST_C);
        if (last_shift) begin
          state_nx = S_IDLE;
        end
      end
      S_RB: begin
        shift_raw  = 1'b1;
        head_raw   = ccff_tail;
        last_shift = (cnt == LAST_C);
        if (last_shift) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Size of the next accepted word: full width, or the tail remainder
  always_comb begin
    rem = LEN_C - acc;
    if (32'(rem) >= WORD_W) begin
      take = RW'(WORD_W);
    end else begin
      take = RW'(rem);
    end
  end

  // Bit-serial CRC-16-CCITT step on the bit entering the chain
  always_comb begin
    crc_fb = crc[15] ^ head_raw;
    crc_nx = {crc[14:0], 1'b0} ^ (crc_fb ? CRC_POLY : 16'h0000);
  end

  // Datapath: word buffer, counters, CRC and completion flags
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      sreg     <= '0;
      reg_cnt  <= '0;
      acc      <= '0;
      cnt      <= '0;
      crc      <= CRC_INIT;
      load_crc <= CRC_INIT;
      loaded   <= 1'b0;
      crc_ok_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == S_IDLE) begin
        if (state_nx != S_IDLE) begin
          crc     <= CRC_INIT;
          cnt     <= '0;
          acc     <= '0;
          reg_cnt <= '0;
          sreg    <= '0;
        end
        if (state_nx == S_LOAD) begin
          loaded <= 1'b0;
        end
      end else begin
        if (shift_raw) begin
          crc <= crc_nx;
          cnt <= cnt + CW'(1);
        end
        if (state == S_LOAD) begin
          // A handshake only happens as the buffer empties, so it replaces the shift.
          if (cfg_valid && ready_raw) begin
            sreg    <= cfg_data;
            reg_cnt <= take;
            acc     <= acc + CW'(take);
          end else if (shift_raw) begin
            sreg    <= sreg << 1;
            reg_cnt <= reg_cnt - RW'(1);
          end
        end
        if (last_shift) begin
          done_q <= 1'b1;
          if (state == S_LOAD) begin
            load_crc <= crc_nx;
            loaded   <= 1'b1;
            crc_ok_q <= 1'b0;
          end else begin
            crc_ok_q <= loaded && (crc_nx == load_crc);
          end
        end
      end
    end
  end

  // Reset gates the strobes in the same cycle it is asserted
  assign ccff_shift_en = shift_raw & prog_reset_n;
  assign cfg_ready     = ready_raw & prog_reset_n;
  assign ccff_head     = head_raw & prog_reset_n;
  assign busy          = (state != S_IDLE);
  assign done          = done_q;
  assign crc_ok        = crc_ok_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: one 64-flop and one 40-flop instance,
// each closed through an ideal chain model.
module tb_ccff_chain_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cfg_data = '0;
  logic        cfg_valid = 1'b0;

  logic ls64 = 1'b0, rs64 = 1'b0, ls40 = 1'b0, rs40 = 1'b0;
  logic ready64, head64, se64, tail64, busy64, done64, ok64;
  logic ready40, head40, se40, tail40, busy40, done40, ok40;
  logic [15:0] crc64, crc40;

  logic [63:0] ch64 = '0;
  logic [39:0] ch40 = '0;
  logic        flip_req = 1'b0;
  int          flip_idx = 0;

  logic sel = 1'b0;
  logic m_ready, m_head, m_se, m_busy, m_done;

  int checks = 0;
  int errors = 0;

  logic [63:0] r_bits;
  int          r_nsh, r_nlow;
  logic        r_done, r_prev_se, r_late_ready;
  logic        r_c0_ready, r_c0_se, r_c0_busy;
  logic        r_se_after, r_busy_after, r_ready_after;
  logic [63:0] saved64;

  always #5 clk = ~clk;

  ccff_chain_loader #(.CHAIN_LEN(64), .WORD_W(32)) dut64 (
    .prog_clk(clk), .prog_reset_n(rst_n), .load_start(ls64), .rb_start(rs64),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(ready64),
    .ccff_head(head64), .ccff_shift_en(se64), .ccff_tail(tail64),
    .busy(busy64), .done(done64), .crc_ok(ok64), .load_crc(crc64)
  );

  ccff_chain_loader #(.CHAIN_LEN(40), .WORD_W(32)) dut40 (
    .prog_clk(clk), .prog_reset_n(rst_n), .load_start(ls40), .rb_start(rs40),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(ready40),
    .ccff_head(head40), .ccff_shift_en(se40), .ccff_tail(tail40),
    .busy(busy40), .done(done40), .crc_ok(ok40), .load_crc(crc40)
  );

  // Ideal chains: first bit shifted in ends at the MSB and leaves first
  always @(posedge clk) begin
    if (flip_req) ch64[flip_idx] <= ~ch64[flip_idx];
    else if (se64) ch64 <= {ch64[62:0], head64};
    if (se40) ch40 <= {ch40[38:0], head40};
  end
  assign tail64 = ch64[63];
  assign tail40 = ch40[39];

  assign m_ready = sel ? ready40 : ready64;
  assign m_head  = sel ? head40  : head64;
  assign m_se    = sel ? se40    : se64;
  assign m_busy  = sel ? busy40  : busy64;
  assign m_done  = sel ? done40  : done64;

  function automatic logic [15:0] crc_ref(input logic [63:0] b, input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[15] ^ b[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // Drive a two-word load; gap = cycles cfg_valid is held low between words,
  // poke_at = shift count at which load_start is re-pulsed, rst_at = shift
  // count at which reset is asserted (-1 = never).
  task automatic run_load(input logic s, input logic [31:0] w0, input logic [31:0] w1,
                          input int gap, input int poke_at, input int rst_at, input logic both);
    int wi;
    int stall;
    sel = s;
    wi = 0;
    stall = gap;
    r_bits = '0; r_nsh = 0; r_nlow = 0; r_done = 0; r_prev_se = 0; r_late_ready = 0;
    @(negedge clk);
    if (s) ls40 = 1'b1; else ls64 = 1'b1;
    if (both) begin
      if (s) rs40 = 1'b1; else rs64 = 1'b1;
    end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      ls40 = 1'b0; ls64 = 1'b0; rs40 = 1'b0; rs64 = 1'b0;
      if (c == 0) begin
        r_c0_ready = m_ready; r_c0_se = m_se; r_c0_busy = m_busy;
      end
      if (m_done) begin
        r_done = 1'b1;
        break;
      end
      r_prev_se = m_se;
      if (m_se) begin
        r_bits = {r_bits[62:0], m_head};
        r_nsh++;
      end else if (r_nsh > 0) begin
        r_nlow++;
      end
      if (wi == 2 && m_ready) r_late_ready = 1'b1;
      if (r_nsh == rst_at) begin
        rst_n = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clk);
        r_se_after = m_se; r_busy_after = m_busy; r_ready_after = m_ready;
        rst_n = 1'b1;
        break;
      end
      if (r_nsh == poke_at) begin
        if (s) ls40 = 1'b1; else ls64 = 1'b1;
      end
      cfg_valid = 1'b0;
      if (wi < 2) begin
        if (wi == 1 && stall > 0 && (m_ready || stall < gap)) begin
          stall--;
        end else begin
          cfg_valid = 1'b1;
          cfg_data  = (wi == 0) ? w0 : w1;
        end
      end
      if (cfg_valid && m_ready) wi++;
    end
    cfg_valid = 1'b0;
    ls40 = 1'b0; ls64 = 1'b0; rs40 = 1'b0; rs64 = 1'b0;
  endtask

  task automatic run_rb(input logic s);
    sel = s;
    r_nsh = 0; r_nlow = 0; r_done = 0; r_prev_se = 0;
    @(negedge clk);
    if (s) rs40 = 1'b1; else rs64 = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      rs40 = 1'b0; rs64 = 1'b0;
      if (m_done) begin
        r_done = 1'b1;
        break;
      end
      r_prev_se = m_se;
      if (m_se) r_nsh++;
      else if (r_nsh > 0) r_nlow++;
    end
    rs40 = 1'b0; rs64 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({busy64, done64, ready64, se64, head64, ok64} !== 6'b0) begin
      errors++; $display("FAIL reset_outs64: got %b want 000000", {busy64, done64, ready64, se64, head64, ok64});
    end
    checks++; if (crc64 !== 16'hFFFF) begin
      errors++; $display("FAIL reset_crc64: got %h want ffff", crc64);
    end
    checks++; if ({busy40, done40, ready40, se40, head40, ok40, crc40} !== {6'b0, 16'hFFFF}) begin
      errors++; $display("FAIL reset_dut40: got %b/%h want 000000/ffff", {busy40, done40, ready40, se40, head40, ok40}, crc40);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({busy64, ready64, se64} !== 3'b0) begin
      errors++; $display("FAIL idle_after_reset: got %b want 000", {busy64, ready64, se64});
    end
  endtask

  task automatic test_rb_no_load;
    run_rb(1'b1);
    checks++; if (r_nsh !== 40 || r_nlow !== 0 || !r_done || !r_prev_se) begin
      errors++; $display("FAIL rb_noload_shifts: got n=%0d low=%0d done=%0d want 40/0/1", r_nsh, r_nlow, r_done);
    end
    checks++; if (ok40 !== 1'b0) begin
      errors++; $display("FAIL rb_noload_crc_ok: got %b want 0", ok40);
    end
  endtask

  task automatic test_load64;
    run_load(1'b0, 32'hDEADBEEF, 32'h01234567, 0, -1, -1, 1'b0);
    checks++; if (r_nsh !== 64 || r_nlow !== 0) begin
      errors++; $display("FAIL load64_count: got n=%0d low=%0d want 64/0", r_nsh, r_nlow);
    end
    checks++; if (r_bits !== 64'hDEADBEEF_01234567) begin
      errors++; $display("FAIL load64_head_bits: got %h want deadbeef01234567", r_bits);
    end
    checks++; if (!r_done || !r_prev_se) begin
      errors++; $display("FAIL load64_done: got done=%0d prev_se=%0d want 1/1", r_done, r_prev_se);
    end
    checks++; if (crc64 !== crc_ref(64'hDEADBEEF_01234567, 64)) begin
      errors++; $display("FAIL load64_crc: got %h want %h", crc64, crc_ref(64'hDEADBEEF_01234567, 64));
    end
    checks++; if (ch64 !== 64'hDEADBEEF_01234567) begin
      errors++; $display("FAIL load64_chain: got %h want deadbeef01234567", ch64);
    end
    checks++; if (r_late_ready !== 1'b0) begin
      errors++; $display("FAIL load64_late_ready: got %b want 0", r_late_ready);
    end
    saved64 = ch64;
  endtask

  task automatic test_load40;
    run_load(1'b1, 32'hFFFFFFFF, 32'hA53C0F77, 0, -1, -1, 1'b0);
    checks++; if (r_nsh !== 40 || r_nlow !== 0 || !r_done) begin
      errors++; $display("FAIL load40_count: got n=%0d low=%0d done=%0d want 40/0/1", r_nsh, r_nlow, r_done);
    end
    checks++; if (r_bits[39:0] !== 40'hFF_FFFF_FFA5) begin
      errors++; $display("FAIL load40_head_bits: got %h want ffffffffa5", r_bits[39:0]);
    end
    checks++; if (r_late_ready !== 1'b0) begin
      errors++; $display("FAIL load40_ready_after_final: got %b want 0", r_late_ready);
    end
    checks++; if (ch40 !== 40'hFF_FFFF_FFA5) begin
      errors++; $display("FAIL load40_chain: got %h want ffffffffa5", ch40);
    end
    checks++; if (crc40 !== crc_ref(64'h00_FFFF_FFFF_A5, 40)) begin
      errors++; $display("FAIL load40_crc: got %h want %h", crc40, crc_ref(64'h00_FFFF_FFFF_A5, 40));
    end
  endtask

  task automatic test_stall;
    run_load(1'b0, 32'hDEADBEEF, 32'h01234567, 5, -1, -1, 1'b0);
    checks++; if (r_nsh !== 64 || r_nlow !== 5) begin
      errors++; $display("FAIL stall_count: got n=%0d low=%0d want 64/5", r_nsh, r_nlow);
    end
    checks++; if (ch64 !== saved64) begin
      errors++; $display("FAIL stall_chain: got %h want %h", ch64, saved64);
    end
  endtask

  task automatic test_readback;
    run_rb(1'b0);
    checks++; if (r_nsh !== 64 || r_nlow !== 0 || !r_done || !r_prev_se) begin
      errors++; $display("FAIL rb_shifts: got n=%0d low=%0d done=%0d want 64/0/1", r_nsh, r_nlow, r_done);
    end
    checks++; if (ch64 !== saved64) begin
      errors++; $display("FAIL rb_chain_kept: got %h want %h", ch64, saved64);
    end
    checks++; if (ok64 !== 1'b1) begin
      errors++; $display("FAIL rb_crc_ok_good: got %b want 1", ok64);
    end
    @(negedge clk);
    flip_idx = 10;
    flip_req = 1'b1;
    @(negedge clk);
    flip_req = 1'b0;
    run_rb(1'b0);
    checks++; if (ok64 !== 1'b0) begin
      errors++; $display("FAIL rb_crc_ok_flipped: got %b want 0", ok64);
    end
    checks++; if (ch64 !== (saved64 ^ 64'h400)) begin
      errors++; $display("FAIL rb_flipped_chain: got %h want %h", ch64, saved64 ^ 64'h400);
    end
  endtask

  task automatic test_start_priority;
    run_load(1'b0, 32'h13579BDF, 32'h2468ACE0, 0, 10, -1, 1'b1);
    checks++; if ({r_c0_busy, r_c0_ready, r_c0_se} !== 3'b110) begin
      errors++; $display("FAIL both_starts_load: got busy,ready,se=%b want 110", {r_c0_busy, r_c0_ready, r_c0_se});
    end
    checks++; if (r_nsh !== 64 || !r_done || r_bits !== 64'h13579BDF_2468ACE0) begin
      errors++; $display("FAIL restart_ignored: got n=%0d bits=%h want 64/13579bdf2468ace0", r_nsh, r_bits);
    end
    checks++; if (crc64 !== crc_ref(64'h13579BDF_2468ACE0, 64)) begin
      errors++; $display("FAIL restart_crc: got %h want %h", crc64, crc_ref(64'h13579BDF_2468ACE0, 64));
    end
  endtask

  task automatic test_reset_mid;
    run_load(1'b0, 32'hCAFEF00D, 32'h55AA33CC, 0, -1, 20, 1'b0);
    checks++; if ({r_se_after, r_busy_after, r_ready_after} !== 3'b000) begin
      errors++; $display("FAIL midreset_outs: got se,busy,ready=%b want 000", {r_se_after, r_busy_after, r_ready_after});
    end
    checks++; if (crc64 !== 16'hFFFF) begin
      errors++; $display("FAIL midreset_load_crc: got %h want ffff", crc64);
    end
    run_rb(1'b0);
    checks++; if (r_nsh !== 64 || ok64 !== 1'b0) begin
      errors++; $display("FAIL midreset_rb: got n=%0d crc_ok=%b want 64/0", r_nsh, ok64);
    end
  endtask

  initial begin
    test_reset;
    test_rb_no_load;
    test_load64;
    test_load40;
    test_stall;
    test_readback;
    test_start_priority;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
